// File: rtl/colormap_engine.sv
// Colormap engine: maps iteration counts to RGB565 through runtime-writable palette banks.
// Optional per-frame palette rotation is enabled by defining COLORMAP_CYCLE_EN.
module colormap_engine #(
  parameter int ITER_W  = 16,
  parameter int PAL_AW  = 8,
  parameter int NBANK   = 4,
  parameter int BANK_W  = 2,
  parameter int SHIFT_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ITER_W-1:0]  iter_count,
  input  logic [ITER_W-1:0]  max_iter,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        rgb565,
  input  logic [BANK_W-1:0]  cfg_bank,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic [PAL_AW-1:0]  cfg_offset,
  input  logic [15:0]        cfg_interior,
  input  logic               wr_en,
  input  logic [BANK_W-1:0]  wr_bank,
  input  logic [PAL_AW-1:0]  wr_addr,
  input  logic [15:0]        wr_data,
  input  logic               frame_tick,
  input  logic [PAL_AW-1:0]  cfg_step
);

  localparam int PAL_SZ = 1 << PAL_AW;
  localparam int DEPTH  = NBANK * PAL_SZ;
  localparam int ADDR_W = BANK_W + PAL_AW;

  typedef logic [DEPTH-1:0][15:0] palette_t;

  // Power-up palette: every bank holds the same ramp, entry index scaled to 8 bits.
  function automatic palette_t grey_ramp();
    palette_t   p;
    logic [7:0] hi;
    for (int a = 0; a < DEPTH; a++) begin
      hi = 8'(((a % PAL_SZ) * 256) / PAL_SZ);
      p[a[ADDR_W-1:0]] = {hi[4:0], hi[5:0], hi[4:0]};
    end
    return p;
  endfunction

  // NOTE: the palette is storage, not state -- it gets a power-up image and is never
  // touched by rst, so loaded palettes survive a pipeline reset.
  palette_t mem = grey_ramp();

  logic stall;
  logic accept;
  logic [PAL_AW-1:0] rot;
  logic [PAL_AW-1:0] idx_next;

  assign stall    = out_valid && !out_ready;
  assign in_ready = !stall;
  assign accept   = in_valid && in_ready;

`ifdef COLORMAP_CYCLE_EN
  logic [PAL_AW-1:0] acc;

  // The accumulator feeds rot combinationally, so a tick in the accept cycle sees the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             acc <= '0;
    else if (frame_tick) acc <= acc + cfg_step;
  end

  assign rot = cfg_offset + acc;
`else
  logic unused_cycle;
  assign unused_cycle = ^{frame_tick, cfg_step};
  assign rot = cfg_offset;
`endif

  assign idx_next = PAL_AW'(iter_count >> cfg_shift) + rot;

  // Stage 1: index, bank and interior decision
  logic              s1_valid;
  logic [PAL_AW-1:0] s1_idx;
  logic [BANK_W-1:0] s1_bank;
  logic              s1_interior;
  logic [15:0]       s1_colour;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_idx      <= '0;
      s1_bank     <= '0;
      s1_interior <= 1'b0;
      s1_colour   <= '0;
    end else if (!stall) begin
      s1_valid <= accept;
      if (accept) begin
        s1_idx      <= idx_next;
        s1_bank     <= cfg_bank;
        s1_interior <= (iter_count >= max_iter);
        s1_colour   <= cfg_interior;
      end
    end
  end

  // Stage 2: synchronous palette read; advances into an empty slot even when stage 1 is empty
  logic [15:0] rd_data;
  logic        s2_interior;
  logic [15:0] s2_colour;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      rd_data     <= '0;
      s2_interior <= 1'b0;
      s2_colour   <= '0;
    end else if (!stall) begin
      out_valid   <= s1_valid;
      rd_data     <= mem[{s1_bank, s1_idx}];
      s2_interior <= s1_interior;
      s2_colour   <= s1_colour;
    end
  end

  // Write port ignores stall; a same-edge read of the same word returns the old data.
  always_ff @(posedge clk) begin
    if (wr_en) mem[{wr_bank, wr_addr}] <= wr_data;
  end

  assign rgb565 = s2_interior ? s2_colour : rd_data;

endmodule

// File: tb/tb_colormap_engine.sv
// Directed self-checking bench for colormap_engine (default parameters).
module tb_colormap_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] iter_count;
  logic [15:0] max_iter;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] rgb565;
  logic [1:0]  cfg_bank;
  logic [2:0]  cfg_shift;
  logic [7:0]  cfg_offset;
  logic [15:0] cfg_interior;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_tick;
  logic [7:0]  cfg_step;

  int checks = 0;
  int errors = 0;

  colormap_engine dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .iter_count(iter_count), .max_iter(max_iter),
    .out_valid(out_valid), .out_ready(out_ready), .rgb565(rgb565),
    .cfg_bank(cfg_bank), .cfg_shift(cfg_shift), .cfg_offset(cfg_offset),
    .cfg_interior(cfg_interior),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_tick(frame_tick), .cfg_step(cfg_step)
  );

  always #5 clk = ~clk;

  task automatic pal_write(input logic [1:0] bank, input logic [7:0] addr, input logic [15:0] data);
    @(negedge clk);
    wr_en = 1'b1; wr_bank = bank; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Sends one sample into an idle pipeline and waits (bounded) for its colour.
  task automatic run_sample(input logic [15:0] iter, input logic tick,
                            output logic [15:0] colour, output int lat, output bit ok);
    @(negedge clk);
    in_valid = 1'b1; iter_count = iter; frame_tick = tick;
    @(negedge clk);
    in_valid = 1'b0; frame_tick = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    ok = out_valid;
    colour = rgb565;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (out_valid !== 1'b0 || rgb565 !== 16'h0000)
      $display("FAIL reset_outputs: out_valid=%b rgb565=%h, want 0/0000", out_valid, rgb565);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0)
      $display("FAIL post_reset: in_ready=%b out_valid=%b, want 1/0", in_ready, out_valid);
    if (in_ready !== 1'b1 || out_valid !== 1'b0) errors++;
    if (out_valid !== 1'b0 || rgb565 !== 16'h0000) errors++;
  endtask

  task automatic test_basic();
    logic [15:0] c; int lat; bit ok;
    pal_write(2'd1, 8'd5, 16'hF800);
    pal_write(2'd0, 8'd5, 16'h1234);
    cfg_bank = 2'd1; cfg_shift = 3'd0; cfg_offset = 8'd0; max_iter = 16'd100;
    run_sample(16'd5, 1'b0, c, lat, ok);
    checks++;
    if (!ok || c !== 16'hF800) begin
      errors++; $display("FAIL basic_colour: got %h (valid=%b), want f800", c, ok);
    end
    checks++;
    if (lat !== 2) begin
      errors++; $display("FAIL basic_latency: got %0d cycles, want 2", lat);
    end
    cfg_bank = 2'd0;
    run_sample(16'd5, 1'b0, c, lat, ok);
    checks++;
    if (!ok || c !== 16'h1234) begin
      errors++; $display("FAIL bank_select: got %h, want 1234", c);
    end
  endtask

  task automatic test_interior();
    logic [15:0] c; int lat; bit ok;
    pal_write(2'd1, 8'd99,  16'h0ABC);
    pal_write(2'd1, 8'd100, 16'hBEEF);
    cfg_bank = 2'd1; cfg_interior = 16'h001F; max_iter = 16'd100;
    run_sample(16'd100, 1'b0, c, lat, ok);
    checks++;
    if (!ok || c !== 16'h001F) begin
      errors++; $display("FAIL interior_eq: got %h, want 001f", c);
    end
    run_sample(16'd99, 1'b0, c, lat, ok);
    checks++;
    if (!ok || c !== 16'h0ABC) begin
      errors++; $display("FAIL below_max: got %h, want 0abc", c);
    end
    max_iter = 16'd0;
    run_sample(16'd0, 1'b0, c, lat, ok);
    checks++;
    if (!ok || c !== 16'h001F) begin
      errors++; $display("FAIL max_zero: got %h, want 001f", c);
    end
    cfg_interior = 16'hFFE0;
    run_sample(16'h1234, 1'b0, c, lat, ok);
    checks++;
    if (!ok || c !== 16'hFFE0) begin
      errors++; $display("FAIL interior_colour: got %h, want ffe0", c);
    end
    max_iter = 16'd100; cfg_interior = 16'h001F;
  endtask

  task automatic test_wrap_shift();
    logic [15:0] c; int lat; bit ok;
    pal_write(2'd0, 8'd4,   16'h4444);
    pal_write(2'd0, 8'd5,   16'h5555);
    pal_write(2'd0, 8'd255, 16'h00FF);
    cfg_bank = 2'd0; cfg_offset = 8'd250; cfg_shift = 3'd0;
    run_sample(16'd10, 1'b0, c, lat, ok);
    checks++;
    if (!ok || c !== 16'h4444) begin
      errors++; $display("FAIL offset_wrap: got %h, want 4444", c);
    end
    cfg_offset = 8'd0; cfg_shift = 3'd2;
    run_sample(16'd20, 1'b0, c, lat, ok);
    checks++;
    if (!ok || c !== 16'h5555) begin
      errors++; $display("FAIL shift2: got %h, want 5555", c);
    end
    max_iter = 16'hFFFF; cfg_shift = 3'd7;
    run_sample(16'hFF80, 1'b0, c, lat, ok);
    checks++;
    if (!ok || c !== 16'h00FF) begin
      errors++; $display("FAIL shift7_trunc: got %h, want 00ff", c);
    end
    cfg_offset = 8'd4;
    run_sample(16'h0050, 1'b0, c, lat, ok);
    checks++;
    if (!ok || c !== 16'h4444) begin
      errors++; $display("FAIL offset_only: got %h, want 4444", c);
    end
    max_iter = 16'd100; cfg_shift = 3'd0; cfg_offset = 8'd0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] q[$];
    logic [15:0] prev_rgb = '0;
    int sent = 0;
    int got = 0;
    bit saw_stall = 0;
    bit prev_stall = 0;
    for (int k = 0; k < 8; k++) pal_write(2'd2, 8'(16 + k), 16'(16'hA010 + k));
    cfg_bank = 2'd2;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      out_ready  = !(cyc >= 5 && cyc < 10);
      in_valid   = (sent < 8);
      iter_count = 16'(16 + sent);
      #1;
      if (out_valid && !out_ready) begin
        saw_stall = 1;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_in_ready: got %b, want 0 (cycle %0d)", in_ready, cyc);
        end
        if (prev_stall) begin
          checks++;
          if (rgb565 !== prev_rgb) begin
            errors++; $display("FAIL stall_hold: got %h, want %h (cycle %0d)", rgb565, prev_rgb, cyc);
          end
        end
        prev_stall = 1; prev_rgb = rgb565;
      end else begin
        prev_stall = 0;
      end
      if (out_valid && out_ready) begin q.push_back(rgb565); got++; end
      if (in_valid && in_ready) sent++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (!saw_stall) begin
      errors++; $display("FAIL stall_seen: got 0, want 1");
    end
    checks++;
    if (got !== 8) begin
      errors++; $display("FAIL stream_count: got %0d, want 8", got);
    end
    for (int k = 0; k < q.size(); k++) begin
      checks++;
      if (q[k] !== 16'(16'hA010 + k)) begin
        errors++; $display("FAIL stream_order[%0d]: got %h, want %h", k, q[k], 16'(16'hA010 + k));
      end
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL stream_extra: out_valid=%b rgb565=%h, want 0", out_valid, rgb565);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_rw_collision();
    logic [15:0] c; int lat; bit ok;
    pal_write(2'd3, 8'd7, 16'h7777);
    cfg_bank = 2'd3;
    @(negedge clk);
    in_valid = 1'b1; iter_count = 16'd7;
    @(negedge clk);
    in_valid = 1'b0;
    wr_en = 1'b1; wr_bank = 2'd3; wr_addr = 8'd7; wr_data = 16'h8888;
    @(negedge clk);
    wr_en = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || rgb565 !== 16'h7777) begin
      errors++; $display("FAIL rw_old_data: valid=%b got %h, want 1/7777", out_valid, rgb565);
    end
    run_sample(16'd7, 1'b0, c, lat, ok);
    checks++;
    if (!ok || c !== 16'h8888) begin
      errors++; $display("FAIL rw_new_data: got %h, want 8888", c);
    end
  endtask

  task automatic test_reset_midstream();
    logic [15:0] c; int lat; bit ok;
    cfg_bank = 2'd2;
    @(negedge clk);
    in_valid = 1'b1; iter_count = 16'd16;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valid: got %b, want 1", out_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || rgb565 !== 16'h0000) begin
      errors++; $display("FAIL reset_async: valid=%b rgb565=%h, want 0/0000", out_valid, rgb565);
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || rgb565 !== 16'h0000) begin
      errors++; $display("FAIL reset_edge: valid=%b rgb565=%h, want 0/0000", out_valid, rgb565);
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL reset_flush: valid=%b in_ready=%b, want 0/1", out_valid, in_ready);
      end
    end
    run_sample(16'd17, 1'b0, c, lat, ok);
    checks++;
    if (!ok || c !== 16'hA011) begin
      errors++; $display("FAIL palette_kept: got %h, want a011", c);
    end
  endtask

  task automatic test_cycle();
    logic [15:0] c; int lat; bit ok;
    logic [15:0] want_a;
    logic [15:0] want_b;
    pal_write(2'd0, 8'd0,  16'h0A0A);
    pal_write(2'd0, 8'd9,  16'h0909);
    pal_write(2'd0, 8'd12, 16'h0C0C);
    cfg_bank = 2'd0; cfg_offset = 8'd0; cfg_shift = 3'd0; cfg_step = 8'd3;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); frame_tick = 1'b1;
      @(negedge clk); frame_tick = 1'b0;
    end
`ifdef COLORMAP_CYCLE_EN
    want_a = 16'h0909; want_b = 16'h0C0C;
`else
    want_a = 16'h0A0A; want_b = 16'h0A0A;
`endif
    run_sample(16'd0, 1'b1, c, lat, ok);
    checks++;
    if (!ok || c !== want_a) begin
      errors++; $display("FAIL cycle_rot: got %h, want %h", c, want_a);
    end
    run_sample(16'd0, 1'b0, c, lat, ok);
    checks++;
    if (!ok || c !== want_b) begin
      errors++; $display("FAIL cycle_after_tick: got %h, want %h", c, want_b);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; iter_count = '0; max_iter = 16'd100; out_ready = 1'b1;
    cfg_bank = '0; cfg_shift = '0; cfg_offset = '0; cfg_interior = 16'h001F;
    wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    frame_tick = 1'b0; cfg_step = '0;
    test_reset();
    test_basic();
    test_interior();
    test_wrap_shift();
    test_back_to_back();
    test_rw_collision();
    test_reset_midstream();
    test_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/colormap_engine.md
Name: colormap_engine

Overview:
Parametrised successor to the single fixed-palette colormap stage: maps Mandelbrot iteration counts to RGB565 through runtime-writable palette banks. Supports index scaling, palette rotation, a programmable interior colour and valid/ready backpressure. Sits between the iteration core result stream and the pixel/framebuffer writer; palette and configuration are loaded by the control CPU/register block.

Parameters:
ITER_W, 16, iteration count width
PAL_AW, 8, log2 palette entries per bank (PAL_SZ = 2^PAL_AW)
NBANK, 4, number of palette banks (power of 2, >=2)
BANK_W, 2, log2(NBANK)
SHIFT_W, 3, width of index right-shift control

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  iteration sample valid
in_ready  out  1  engine accepts sample
iter_count  in  ITER_W  iteration count
max_iter  in  ITER_W  escape limit; iter_count >= max_iter is interior
out_valid  out  1  colour valid
out_ready  in  1  downstream accepts colour
rgb565  out  16  output colour
cfg_bank  in  BANK_W  active read bank, sampled per accepted sample
cfg_shift  in  SHIFT_W  index = iter_count >> cfg_shift
cfg_offset  in  PAL_AW  base palette rotation
cfg_interior  in  16  colour for interior points
wr_en  in  1  palette write strobe
wr_bank  in  BANK_W  palette write bank
wr_addr  in  PAL_AW  palette write entry
wr_data  in  16  palette write data
frame_tick  in  1  one-cycle pulse per frame (used only with cycling)
cfg_step  in  PAL_AW  rotation increment per frame (used only with cycling)

Behaviour:
- Two-stage pipeline, latency 2 cycles from accepted input to out_valid when not stalled; throughput 1 sample/cycle.
- Stage 1 (on in_valid && in_ready): idx = ((iter_count >> cfg_shift) + rot)[PAL_AW-1:0] (modulo PAL_SZ wrap); registers idx, cfg_bank, interior flag, cfg_interior.
- Stage 2: synchronous palette read at {bank, idx}; rgb565 = interior ? captured interior colour : palette word.
- Stall: stall = out_valid && !out_ready; in_ready = !stall; when stalled both stages and the RAM output register hold; rgb565 stable while out_valid && !out_ready.
- Pipeline bubbles collapse: stage 2 may advance into an empty output slot even if stage 1 is empty.
- Palette RAM NBANK*PAL_SZ x 16, single write port independent of stall; write and read of same address in same cycle returns old data.
- RAM not cleared by reset; initial content every bank entry i = grey ramp {i_hi[4:0], i_hi[5:0], i_hi[4:0]} with i_hi = i scaled to 8 bits.
- Reset: out_valid=0, rgb565=16'h0000, internal valids=0, rotation accumulator=0; in_ready=1 after reset. Reset mid-stream discards in-flight samples.
- max_iter=0: every sample interior. cfg_shift beyond ITER_W-1 legal (index from offset only).
- Config inputs changing between samples apply to the next accepted sample only.

Optional Feature:
COLORMAP_CYCLE_EN: defined -> rot = cfg_offset + acc, acc (PAL_AW bits) += cfg_step on each frame_tick, wrapping modulo PAL_SZ; frame_tick coincident with accepted sample uses pre-update acc. Undefined -> rot = cfg_offset; frame_tick, cfg_step ignored, no accumulator.

Test Plan:
- Write bank1 entry 5 = 16'hF800, cfg_bank=1, shift=0, offset=0, iter=5, max=100 -> rgb565=16'hF800 exactly 2 cycles after acceptance.
- iter=100, max=100, cfg_interior=16'h001F -> 16'h001F regardless of palette; max_iter=0 with iter=0 -> 16'h001F.
- offset=250, iter=10, PAL_AW=8 -> entry 4 read (wrap); shift=2, iter=20, offset=0 -> entry 5.
- Stream 8 samples, hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 during stall, rgb565 stable, no loss/duplication, order preserved.
- Same-cycle write/read of entry 7 -> read gets old value; next sample gets new; assert rst mid-stream -> out_valid=0, rgb565=0 next edge.
- With COLORMAP_CYCLE_EN: step=3, three frame_ticks, offset=0, iter=0 -> entry 9 read; without macro -> entry 0.
